// File: rtl/pwm_pkg.sv
// Shared register-map offsets, CONTROL bit positions and CONTROL layout for the PWM bank.
// The optional interrupt bits (CONTROL[4:3]) are only live when PWM_IRQ_EN is defined.
package pwm_pkg;

    localparam int PERIOD_OFF  = 0;
    localparam int DUTY_OFF    = 1;
    localparam int CONTROL_OFF = 2;
    localparam int COUNT_OFF   = 3;
    localparam int REGS_PER_CH = 4;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_POLARITY = 1;
    localparam int CTRL_FORCE    = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_IRQ_PEND = 4;

    typedef struct packed {
        logic [26:0] reserved;
        logic        irq_pending;
        logic        irq_enable;
        logic        force_update;
        logic        polarity;
        logic        enable;
    } ctrl_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: programmed PERIOD/DUTY/CONTROL, active shadows, counter and comparator.
// With PWM_IRQ_EN defined it also keeps irq_enable/irq_pending and exposes irq_req.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [REGS_PER_CH-1:0]       w_enable,
    input  logic [31:0]                  w_data,
    output logic [REGS_PER_CH-1:0][31:0] read_data,
    output logic                         pwm_out
`ifdef PWM_IRQ_EN
    ,
    output logic                         irq_req
`endif
);

    logic [CNT_WIDTH-1:0] period, duty, shadow_period, shadow_duty, count;
    logic [CNT_WIDTH-1:0] wr_val, period_next, duty_next;
    logic                 enable, polarity;
    logic                 wr_period, wr_duty, wr_ctrl;
    logic                 start, force_load, running, wrap, load, active;
    logic                 unused_count_wr;
    ctrl_t                ctrl_rd;

    assign wr_val          = w_data[CNT_WIDTH-1:0];
    assign wr_period       = w_enable[PERIOD_OFF];
    assign wr_duty         = w_enable[DUTY_OFF];
    assign wr_ctrl         = w_enable[CONTROL_OFF];
    assign unused_count_wr = w_enable[COUNT_OFF];

    // A restart (enable rising or force_update) reloads the shadows and restarts the count at 0.
    assign start       = wr_ctrl && w_data[CTRL_ENABLE] && !enable;
    assign force_load  = wr_ctrl && w_data[CTRL_FORCE];
    assign running     = enable && (shadow_period != '0);
    assign wrap        = running && (count == shadow_period - CNT_WIDTH'(1));
    assign load        = wrap || start || force_load;
    assign period_next = wr_period ? wr_val : period;
    assign duty_next   = wr_duty ? wr_val : duty;
    assign active      = running && (count < shadow_duty);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            period        <= '0;
            duty          <= '0;
            enable        <= 1'b0;
            polarity      <= 1'b0;
            shadow_period <= '0;
            shadow_duty   <= '0;
            count         <= '0;
            pwm_out       <= 1'b0;
        end else begin
            period <= period_next;
            duty   <= duty_next;
            if (wr_ctrl) begin
                enable   <= w_data[CTRL_ENABLE];
                polarity <= w_data[CTRL_POLARITY];
            end
            if (load) begin
                shadow_period <= period_next;
                shadow_duty   <= duty_next;
            end
            if (!running || start || force_load || wrap) begin
                count <= '0;
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
            pwm_out <= active ^ polarity;
        end
    end

`ifdef PWM_IRQ_EN
    logic irq_enable, irq_pending;

    // A wrap in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq_enable  <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_enable <= w_data[CTRL_IRQ_EN];
            end
            if (wrap) begin
                irq_pending <= 1'b1;
            end else if (wr_ctrl && w_data[CTRL_IRQ_PEND]) begin
                irq_pending <= 1'b0;
            end
        end
    end

    assign irq_req = irq_pending && irq_enable;
`endif

    always_comb begin
        ctrl_rd          = '0;
        ctrl_rd.enable   = enable;
        ctrl_rd.polarity = polarity;
`ifdef PWM_IRQ_EN
        ctrl_rd.irq_enable  = irq_enable;
        ctrl_rd.irq_pending = irq_pending;
`endif
        read_data                              = '0;
        read_data[PERIOD_OFF][CNT_WIDTH-1:0]   = period;
        read_data[DUTY_OFF][CNT_WIDTH-1:0]     = duty;
        read_data[CONTROL_OFF]                 = ctrl_rd;
        read_data[COUNT_OFF][CNT_WIDTH-1:0]    = count;
    end

endmodule

// File: rtl/pwm_channel_bank.sv
// Bank of NUM_CHANNELS PWM channels behind the APB slave's one-hot register strobes.
// Defining PWM_IRQ_EN adds the registered, OR-combined irq output.
module pwm_channel_bank
    import pwm_pkg::*;
#(
    parameter  int NUM_CHANNELS = 4,
    parameter  int CNT_WIDTH    = 32,
    localparam int NUM_REGS     = REGS_PER_CH * NUM_CHANNELS
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REGS-1:0]       w_enable,
    input  logic [NUM_REGS-1:0]       r_enable,
    input  logic [31:0]               w_data,
    output logic [NUM_REGS-1:0][31:0] read_data,
    output logic [NUM_CHANNELS-1:0]   pwm_out
`ifdef PWM_IRQ_EN
    ,
    output logic                      irq
`endif
);

    // Reads have no side effects; r_enable is reserved for future read-clear flags.
    logic unused_r_enable;
    assign unused_r_enable = ^r_enable;

`ifdef PWM_IRQ_EN
    logic [NUM_CHANNELS-1:0] irq_req;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |irq_req;
        end
    end
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        pwm_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_channel (
            .clk      (clk),
            .n_rst    (n_rst),
            .w_enable (w_enable[c*REGS_PER_CH +: REGS_PER_CH]),
            .w_data   (w_data),
            .read_data(read_data[c*REGS_PER_CH +: REGS_PER_CH]),
            .pwm_out  (pwm_out[c])
`ifdef PWM_IRQ_EN
            ,
            .irq_req  (irq_req[c])
`endif
        );
    end

endmodule
